// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: handshake and addressing bundle between a producer/consumer
// pair and the fifo_ctrl pointer/flag controller.
//   wr, rd          push / pop requests (level, sampled each clk)
//   wr_en           reg_file write enable
//   w_addr, r_addr  reg_file write / read addresses (write / read pointers)
//   full, empty     occupancy flags
//   count           occupancy, 0..2**ADDR_WIDTH
// The master modport is the producer/consumer side; slave is the controller.
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 2
);
    logic                  wr;
    logic                  rd;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output wr, rd,
        input  wr_en, w_addr, r_addr, full, empty, count
    );

    modport slave (
        input  wr, rd,
        output wr_en, w_addr, r_addr, full, empty, count
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller that runs an external reg_file
// (write port plus asynchronous read port) as a circular FIFO of depth
// 2**ADDR_WIDTH. Data never passes through this block.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fifo_ctrl_if slave: wr/rd requests in; wr_en, w_addr, r_addr,
//          full, empty and count out
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  full_q;
    logic                  empty_q;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [ADDR_WIDTH:0]   cnt_dec;

    // A push into a full FIFO is still accepted when a pop happens in the
    // same cycle: the head slot is freed at the same edge the new word lands.
    // Both accepts are held off while reset is asserted so wr_en stays low.
    always_comb begin
        rd_ok   = bus.rd & ~empty_q & rst_n;
        wr_ok   = bus.wr & (~full_q | bus.rd) & rst_n;
        cnt_inc = cnt + CNT_ONE;
        cnt_dec = cnt - CNT_ONE;
    end

    assign bus.wr_en  = wr_ok;
    assign bus.w_addr = w_ptr;
    assign bus.r_addr = r_ptr;
    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.count  = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10: begin
                    w_ptr   <= w_ptr + PTR_ONE;
                    cnt     <= cnt_inc;
                    empty_q <= 1'b0;
                    full_q  <= (cnt_inc == CNT_DEPTH);
                end
                2'b01: begin
                    r_ptr   <= r_ptr + PTR_ONE;
                    cnt     <= cnt_dec;
                    full_q  <= 1'b0;
                    empty_q <= (cnt_dec == '0);
                end
                2'b11: begin
                    w_ptr <= w_ptr + PTR_ONE;
                    r_ptr <= r_ptr + PTR_ONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic [7:0] mem [DEPTH];

    int errors;
    int checks;

    // Reference model: FIFO contents as a queue plus running push/pop totals.
    logic [7:0] model_q [$];
    int unsigned pushes;
    int unsigned pops;

    fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reg_file: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.w_addr] <= wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        pushes = 0;
        pops   = 0;
    endtask

    task automatic check_state(input logic exp_wr_en);
        int unsigned n;
        n = model_q.size();
        check("count",  32'(bus.count),  32'(n));
        check("full",   32'(bus.full),   32'(n == DEPTH));
        check("empty",  32'(bus.empty),  32'(n == 0));
        check("w_addr", 32'(bus.w_addr), pushes % DEPTH);
        check("r_addr", 32'(bus.r_addr), pops % DEPTH);
        check("wr_en",  32'(bus.wr_en),  32'(exp_wr_en));
        if (n != 0) check("head", 32'(mem[bus.r_addr]), 32'(model_q[0]));
    endtask

    // One clock: drive just after a rising edge, check at the falling edge,
    // then apply the model's view of the accept rules at the next rising edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        bit do_push;
        bit do_pop;
        bus.wr = w;
        bus.rd = r;
        wdata  = d;
        @(negedge clk);
        do_pop  = r && (model_q.size() > 0);
        do_push = w && ((model_q.size() < DEPTH) || r);
        check_state(do_push);
        @(posedge clk);
        if (do_pop) begin
            void'(model_q.pop_front());
            pops++;
        end
        if (do_push) begin
            model_q.push_back(d);
            pushes++;
        end
        #1;
    endtask

    initial begin
        logic [7:0] seq [4];
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        wdata  = '0;
        model_reset();
        #12;
        check_state(1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset.
        repeat (3) cycle(1'b0, 1'b0, 8'h00);

        // Fill, then overflow attempt.
        seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, seq[i]);
        cycle(1'b1, 1'b0, 8'hE5);

        // Drain, then underflow attempt.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);

        // Simultaneous from empty, held long enough to wrap both pointers.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 8'h11);

        // Fill to full with pointers at 2/2, then simultaneous push/pop.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h22 + i));
        check("ptr_at_full", {30'd0, bus.w_addr} | ({30'd0, bus.r_addr} << 4), 32'h22);
        cycle(1'b1, 1'b1, 8'h77);
        check("ptr_after_rw", {30'd0, bus.w_addr} | ({30'd0, bus.r_addr} << 4), 32'h33);
        repeat (2) cycle(1'b0, 1'b0, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic r;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            cycle(w, r, 8'($urandom));
        end

        // Drain, push three, then asynchronous reset mid-cycle.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
        bus.wr = 1'b1;
        bus.rd = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state(1'b0);
        @(negedge clk);
        check_state(1'b0);
        #2;
        rst_n = 1'b1;
        bus.wr = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h5A);
        cycle(1'b0, 1'b0, 8'h00);
        check("post_reset_count", 32'(bus.count), 32'd1);
        check("post_reset_waddr", 32'(bus.w_addr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
